// File: rtl/core101_pkg.sv
// rtl/core101_pkg.sv - shared constants for the memory-port arbiter slice
package core101_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with optional LSU priority
module rr_arbiter2
  import core101_pkg::*;
#(
  parameter int LSU_PRIORITY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic accept,
  output logic any_req,
  output logic winner
);

  logic rr_last;

  // Pick the winner: a lone requester wins, a tie goes away from the last grant
  always_comb begin
    any_req = ifu_req | lsu_req;
    if (ifu_req && lsu_req) begin
      winner = (LSU_PRIORITY != 0) ? REQ_LSU : ~rr_last;
    end else if (lsu_req) begin
      winner = REQ_LSU;
    end else begin
      winner = REQ_IFU;
    end
  end

  // Remember who was granted last; reset to IFU so the first tie favours LSU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= REQ_IFU;
    end else if (accept) begin
      rr_last <= winner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
module mem_port_arbiter
  import core101_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LSU_PRIORITY   = 0
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic            ifu_req_in,
  input  logic [XLEN-1:0] ifu_addr_in,
  output logic            ifu_gnt_out,
  output logic            ifu_valid_out,
  output logic [XLEN-1:0] ifu_data_out,
  input  logic            lsu_req_in,
  input  logic            lsu_we_in,
  input  logic [XLEN-1:0] lsu_addr_in,
  input  logic [XLEN-1:0] lsu_wdata_in,
  input  logic [3:0]      lsu_be_in,
  output logic            lsu_gnt_out,
  output logic            lsu_valid_out,
  output logic [XLEN-1:0] lsu_rdata_out,
  output logic            err_out,
  output logic [XLEN-1:0] mem_addr_out,
  output logic [XLEN-1:0] mem_wdata_out,
  output logic [3:0]      mem_be_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  input  logic [XLEN-1:0] mem_rdata_in,
  input  logic            mem_valid_in,
  output logic            busy_out
);

  // A zero-cycle watchdog still needs a one-bit counter to keep the logic legal
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic WDOG_ON = (TIMEOUT_CYCLES != 0);

  state_t        state, state_nxt;
  logic          any_req, winner, owner, gnt_q, err_flag;
  logic [CW-1:0] cnt;
  logic          grant, mem_done, timeout_hit;

  rr_arbiter2 #(.LSU_PRIORITY(LSU_PRIORITY)) u_arb (
    .clk     (clock_in),
    .rst     (reset_in),
    .ifu_req (ifu_req_in),
    .lsu_req (lsu_req_in),
    .accept  (grant),
    .any_req (any_req),
    .winner  (winner)
  );

  // Transfer events; memory completion counts only while a transfer is in flight
  always_comb begin
    grant       = (state == IDLE) && any_req;
    mem_done    = (state == ACCESS) && mem_valid_in;
    timeout_hit = (state == ACCESS) && !mem_valid_in && WDOG_ON && (cnt == TO_LAST);
  end

  // State register
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: arbitrate, wait for memory or the watchdog, then one response cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  if (mem_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state and the owner of the transfer
  always_comb begin
    busy_out      = (state != IDLE);
    ifu_gnt_out   = gnt_q && (owner == REQ_IFU);
    lsu_gnt_out   = gnt_q && (owner == REQ_LSU);
    ifu_valid_out = (state == RESP) && (owner == REQ_IFU);
    lsu_valid_out = (state == RESP) && (owner == REQ_LSU);
    err_out       = (state == RESP) && err_flag;
  end

  // Datapath: latch the winner's request, run the watchdog, capture the response
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      gnt_q         <= 1'b0;
      owner         <= REQ_IFU;
      cnt           <= '0;
      err_flag      <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_be_out    <= '0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      ifu_data_out  <= '0;
      lsu_rdata_out <= '0;
    end else begin
      gnt_q <= grant;
      if (grant) begin
        owner    <= winner;
        cnt      <= '0;
        err_flag <= 1'b0;
        if (winner == REQ_LSU) begin
          mem_addr_out  <= lsu_addr_in;
          mem_wdata_out <= lsu_wdata_in;
          mem_be_out    <= lsu_be_in;
          mem_read_out  <= ~lsu_we_in;
          mem_write_out <= lsu_we_in;
        end else begin
          mem_addr_out  <= ifu_addr_in;
          mem_wdata_out <= '0;
          mem_be_out    <= 4'hF;
          mem_read_out  <= 1'b1;
          mem_write_out <= 1'b0;
        end
      end else if (mem_done) begin
        mem_read_out  <= 1'b0;
        mem_write_out <= 1'b0;
        // A write completion is only an acknowledge; the held read word stays
        if (!mem_write_out) begin
          if (owner == REQ_IFU) ifu_data_out  <= mem_rdata_in;
          else                  lsu_rdata_out <= mem_rdata_in;
        end
      end else if (timeout_hit) begin
        mem_read_out  <= 1'b0;
        mem_write_out <= 1'b0;
        err_flag      <= 1'b1;
        if (owner == REQ_IFU) ifu_data_out  <= '0;
        else                  lsu_rdata_out <= '0;
      end else if (state == ACCESS) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else if (state == RESP) begin
        cnt      <= '0;
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req, lsu_req, lsu_we, mem_valid;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_be;

  logic        ifu_gnt, ifu_valid, lsu_gnt, lsu_valid, err, rd, wr, busy;
  logic [31:0] ifu_data, lsu_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        p_ifu_gnt, p_ifu_valid, p_lsu_gnt, p_lsu_valid, p_err, p_rd, p_wr, p_busy;
  logic [31:0] p_ifu_data, p_lsu_rdata, p_mem_addr, p_mem_wdata;
  logic [3:0]  p_mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8), .LSU_PRIORITY(0)) dut (
    .clock_in(clk), .reset_in(rst),
    .ifu_req_in(ifu_req), .ifu_addr_in(ifu_addr), .ifu_gnt_out(ifu_gnt),
    .ifu_valid_out(ifu_valid), .ifu_data_out(ifu_data),
    .lsu_req_in(lsu_req), .lsu_we_in(lsu_we), .lsu_addr_in(lsu_addr),
    .lsu_wdata_in(lsu_wdata), .lsu_be_in(lsu_be), .lsu_gnt_out(lsu_gnt),
    .lsu_valid_out(lsu_valid), .lsu_rdata_out(lsu_rdata), .err_out(err),
    .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata), .mem_be_out(mem_be),
    .mem_read_out(rd), .mem_write_out(wr), .mem_rdata_in(mem_rdata),
    .mem_valid_in(mem_valid), .busy_out(busy)
  );

  mem_port_arbiter #(.LSU_PRIORITY(1)) dut_pri (
    .clock_in(clk), .reset_in(rst),
    .ifu_req_in(ifu_req), .ifu_addr_in(ifu_addr), .ifu_gnt_out(p_ifu_gnt),
    .ifu_valid_out(p_ifu_valid), .ifu_data_out(p_ifu_data),
    .lsu_req_in(lsu_req), .lsu_we_in(lsu_we), .lsu_addr_in(lsu_addr),
    .lsu_wdata_in(lsu_wdata), .lsu_be_in(lsu_be), .lsu_gnt_out(p_lsu_gnt),
    .lsu_valid_out(p_lsu_valid), .lsu_rdata_out(p_lsu_rdata), .err_out(p_err),
    .mem_addr_out(p_mem_addr), .mem_wdata_out(p_mem_wdata), .mem_be_out(p_mem_be),
    .mem_read_out(p_rd), .mem_write_out(p_wr), .mem_rdata_in(mem_rdata),
    .mem_valid_in(mem_valid), .busy_out(p_busy)
  );

  typedef struct {
    logic        ifu;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
    int          exp_strobes;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
  } vec_t;

  vec_t tbl [7];
  vec_t fv;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_now();
    return {24'b0, busy, ifu_gnt, lsu_gnt, ifu_valid, lsu_valid, err, rd, wr};
  endfunction

  task automatic idle_inputs();
    ifu_req = 0; ifu_addr = 0; lsu_req = 0; lsu_we = 0; lsu_addr = 0;
    lsu_wdata = 0; lsu_be = 0; mem_valid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk32({tag, "_ctrl"}, ctrl_now(), 32'h0);
    chk32({tag, "_ifu_data"}, ifu_data, 32'h0);
    chk32({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk32({tag, "_mem_be"}, 32'(mem_be), 32'h0);
  endtask

  // One isolated transfer from a single requester; DUT must be idle on entry
  task automatic run_vec(input int idx, input vec_t v);
    int strobes = 0, vcyc = -1, gcnt = 0, gk = -1;
    logic gside = 0, vside = 0, grd = 0, gwe = 0, gerr = 0;
    logic [31:0] ga = 0, gw = 0, gdata = 0;
    logic [3:0] gb = 0;
    string tag = $sformatf("vec%0d", idx);
    ifu_req = v.ifu; ifu_addr = v.addr;
    lsu_req = !v.ifu; lsu_we = v.we; lsu_addr = v.addr; lsu_wdata = v.wdata; lsu_be = v.be;
    mem_valid = 0; mem_rdata = v.rdata;
    for (int k = 0; k < 20 && vcyc < 0; k++) begin
      @(negedge clk);
      if (ifu_gnt || lsu_gnt) begin gcnt++; gk = k; gside = lsu_gnt; end
      if (rd || wr) strobes++;
      if (k == 1) begin ga = mem_addr; gw = mem_wdata; gb = mem_be; grd = rd; gwe = wr; end
      if (ifu_valid || lsu_valid) begin
        vcyc = k; vside = lsu_valid; gerr = err;
        gdata = v.ifu ? ifu_data : lsu_rdata;
      end
      @(posedge clk);
      #1 mem_valid = (k + 1 == v.lat);
    end
    ifu_req = 0; lsu_req = 0; mem_valid = 0;
    chk32({tag, "_gnt_count"}, gcnt, 1);
    chk32({tag, "_gnt_cycle"}, gk, 1);
    chk32({tag, "_gnt_side"}, 32'(gside), 32'(!v.ifu));
    chk32({tag, "_strobes"}, strobes, v.exp_strobes);
    chk32({tag, "_rd_wr"}, 32'({grd, gwe}), 32'({!v.we, v.we}));
    chk32({tag, "_mem_addr"}, ga, v.addr);
    chk32({tag, "_mem_be"}, 32'(gb), 32'(v.exp_be));
    if (v.we) chk32({tag, "_mem_wdata"}, gw, v.wdata);
    chk32({tag, "_valid_cycle"}, vcyc, v.exp_strobes + 1);
    chk32({tag, "_valid_side"}, 32'(vside), 32'(!v.ifu));
    chk32({tag, "_err"}, 32'(gerr), 32'(v.exp_err));
    chk32({tag, "_data"}, gdata, v.exp_data);
  endtask

  // Random traffic checked against a transaction-level timing model
  task automatic run_random(input int ncyc);
    logic        rq [2];
    logic [31:0] ra [2];
    logic        rwe [2];
    logic [31:0] rwd [2];
    logic [3:0]  rbe [2];
    logic [31:0] xd [2];
    int   e = -100, L = 0, lat;
    logic win = 0, to = 0, rr_last = 0, t_we = 0;
    logic [31:0] t_addr = 0, t_wd = 0;
    logic [3:0]  t_be = 0;
    logic in_acc, resp, busy_m;
    logic [31:0] exp;
    for (int s = 0; s < 2; s++) begin
      rq[s] = 0; ra[s] = 0; rwe[s] = 0; rwd[s] = 0; rbe[s] = 0; xd[s] = 0;
    end
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (c == e + L + 1) rq[win] = 0;
      for (int s = 0; s < 2; s++) begin
        if (!rq[s] && $urandom_range(0, 2) == 0) begin
          rq[s] = 1; ra[s] = $urandom; rwd[s] = $urandom;
          rwe[s] = (s == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          rbe[s] = 4'($urandom_range(0, 15));
        end
      end
      in_acc = (c >= e) && (c <= e + L - 1);
      resp   = (c == e + L);
      busy_m = (c >= e) && (c <= e + L);
      mem_valid = in_acc ? (!to && (c == e + L - 1)) : ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      ifu_req = rq[0]; ifu_addr = ra[0];
      lsu_req = rq[1]; lsu_addr = ra[1]; lsu_we = rwe[1]; lsu_wdata = rwd[1]; lsu_be = rbe[1];
      exp = {24'b0, busy_m, (c == e) && !win, (c == e) && win, resp && !win, resp && win,
             resp && to, in_acc && !t_we, in_acc && t_we};
      @(negedge clk);
      chk32($sformatf("rnd_ctrl_c%0d", c), ctrl_now(), exp);
      chk32($sformatf("rnd_ifu_data_c%0d", c), ifu_data, xd[0]);
      chk32($sformatf("rnd_lsu_rdata_c%0d", c), lsu_rdata, xd[1]);
      if (in_acc) begin
        chk32($sformatf("rnd_addr_c%0d", c), mem_addr, t_addr);
        chk32($sformatf("rnd_be_c%0d", c), 32'(mem_be), 32'(t_be));
        if (t_we) chk32($sformatf("rnd_wdata_c%0d", c), mem_wdata, t_wd);
      end
      if (in_acc && (c == e + L - 1)) begin
        if (to) xd[win] = 0;
        else if (!t_we) xd[win] = mem_rdata;
      end
      if (!busy_m && (rq[0] || rq[1])) begin
        win = (rq[0] && rq[1]) ? !rr_last : rq[1];
        rr_last = win;
        lat = $urandom_range(1, 10);
        to = (lat > 8);
        L = to ? 8 : lat;
        e = c + 1;
        t_addr = ra[win]; t_we = rwe[win]; t_wd = rwd[win];
        t_be = win ? rbe[1] : 4'hF;
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    #1000000;
    $display("FAIL sim_watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int ng, np, vcount, vk;
    logic gs [4];
    logic ps [4];
    logic [31:0] vdat;

    tbl[0] = '{1'b1, 32'h8,   1'b0, 32'h0,        4'h0, 1, 32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF, 4'hF};
    tbl[1] = '{1'b0, 32'h200, 1'b0, 32'h0,        4'hC, 3, 32'hCAFEF00D, 3, 1'b0, 32'hCAFEF00D, 4'hC};
    tbl[2] = '{1'b0, 32'h100, 1'b1, 32'h12345678, 4'h3, 5, 32'h55555555, 5, 1'b0, 32'hCAFEF00D, 4'h3};
    tbl[3] = '{1'b1, 32'h40,  1'b0, 32'h0,        4'h0, 9, 32'h11111111, 8, 1'b1, 32'h0,        4'hF};
    tbl[4] = '{1'b1, 32'h44,  1'b0, 32'h0,        4'h0, 2, 32'h0BADF00D, 2, 1'b0, 32'h0BADF00D, 4'hF};
    tbl[5] = '{1'b0, 32'h300, 1'b1, 32'h9ABCDEF0, 4'hF, 8, 32'h77777777, 8, 1'b0, 32'hCAFEF00D, 4'hF};
    tbl[6] = '{1'b0, 32'h304, 1'b0, 32'h0,        4'h1, 9, 32'h22222222, 8, 1'b1, 32'h0,        4'h1};
    fv     = '{1'b1, 32'h84,  1'b0, 32'h0,        4'h0, 1, 32'h600DCAFE, 1, 1'b0, 32'h600DCAFE, 4'hF};

    do_reset();
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;

    // Both sides request continuously from reset
    ifu_req = 1; ifu_addr = 32'h10; lsu_req = 1; lsu_we = 0; lsu_addr = 32'h20; mem_valid = 1;
    ng = 0; np = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if ((ifu_gnt || lsu_gnt) && ng < 4) begin gs[ng] = lsu_gnt; ng++; end
      if ((p_ifu_gnt || p_lsu_gnt) && np < 4) begin ps[np] = p_lsu_gnt; np++; end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    chk32("tie_rr_count", ng, 4);
    chk32("tie_pri_count", np, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) chk32($sformatf("tie_rr_%0d_lsu", i), 32'(gs[i]), 32'(i % 2 == 0));
      if (i < np) chk32($sformatf("tie_pri_%0d_lsu", i), 32'(ps[i]), 32'h1);
    end

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Reset in the middle of an ACCESS phase
    ifu_req = 1; ifu_addr = 32'h80; mem_valid = 0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk32("pre_reset_ctrl", ctrl_now(), 32'h82);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    ifu_req = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    run_vec(7, fv);

    // Spurious completion while idle, then a requester that drops mid-ACCESS
    mem_valid = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk32($sformatf("spurious_%0d_ctrl", k), ctrl_now(), 32'h0);
      @(posedge clk);
      #1;
    end
    chk32("spurious_data_held", ifu_data, 32'h600DCAFE);
    mem_valid = 0; ifu_req = 1; ifu_addr = 32'h1000; mem_rdata = 32'hA5A5A5A5;
    vcount = 0; vk = -1; vdat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ifu_valid) begin vcount++; vk = k; vdat = ifu_data; end
      @(posedge clk);
      #1;
      if (k + 1 == 2) ifu_req = 0;
      mem_valid = (k + 1 == 3);
    end
    chk32("drop_valid_count", vcount, 1);
    chk32("drop_valid_cycle", vk, 4);
    chk32("drop_data", vdat, 32'hA5A5A5A5);

    run_random(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
